// File: rtl/alert_scheduler_if.sv
// Buzzer scheduler bus: request/tick/ack inputs towards the scheduler and
// buzzer/status outputs back to the main controller. The current FSM state
// is carried alongside so checkers can observe it directly.
//
// Handshake: there is no valid/ready pair. req, tick and ack are one-cycle
// pulses sampled on the rising clock edge, and every output is a registered
// or state-decoded level that is valid throughout each cycle.
interface alert_scheduler_if;
    logic       tick;
    logic [3:0] req;
    logic       ack;
    logic       buzz_en;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] pending;
    logic [2:0] missed;
    logic [2:0] state;

    modport master (
        output tick, req, ack,
        input  buzz_en, grant, busy, pending, missed, state
    );

    modport slave (
        input  tick, req, ack,
        output buzz_en, grant, busy, pending, missed, state
    );
endinterface

// File: rtl/alert_scheduler.sv
// Shares one buzzer between three round-robin dose alarms (ids 0-2) and a
// low-priority key click (id 3). Alarms sound ON/OFF bursts until they are
// acknowledged or the burst limit runs out. A click is one short beep.
module alert_scheduler #(
    parameter int ON_MS      = 200,
    parameter int OFF_MS     = 300,
    parameter int CLICK_MS   = 20,
    parameter int MAX_BURSTS = 10,
    parameter int CNT_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    alert_scheduler_if.slave   bus
);
    localparam int BW = $clog2(MAX_BURSTS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ON    = 3'd1,
        S_OFF   = 3'd2,
        S_CLICK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [BW-1:0]    burst;
    logic [1:0]       owner;
    logic [1:0]       last_rr;
    logic [3:0]       pending;
    logic [2:0]       missed;

    logic [1:0]       rr_first, rr_second, rr_third, rr_pick;
    logic [3:0]       owner_vec;
    logic [3:0]       clr_mask;
    logic [2:0]       miss_set;

    assign owner_vec = 4'b0001 << owner;

    // Round-robin pick: first pending alarm searching upward from last_rr+1.
    always_comb begin
        rr_first  = 2'd0;
        rr_second = 2'd1;
        rr_third  = 2'd2;
        case (last_rr)
            2'd0: begin rr_first = 2'd1; rr_second = 2'd2; rr_third = 2'd0; end
            2'd1: begin rr_first = 2'd2; rr_second = 2'd0; rr_third = 2'd1; end
            default: begin rr_first = 2'd0; rr_second = 2'd1; rr_third = 2'd2; end
        endcase
        if (pending[rr_first])
            rr_pick = rr_first;
        else if (pending[rr_second])
            rr_pick = rr_second;
        else
            rr_pick = rr_third;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; ack beats a same-cycle counter expiry in ON/OFF.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (pending[2:0] != 3'b000)
                    state_next = S_ON;
                else if (pending[3])
                    state_next = S_CLICK;
            end
            S_ON: begin
                if (bus.ack)
                    state_next = S_DONE;
                else if (bus.tick && cnt == CNT_W'(ON_MS - 1))
                    state_next = S_OFF;
            end
            S_OFF: begin
                if (bus.ack)
                    state_next = S_DONE;
                else if (bus.tick && cnt == CNT_W'(OFF_MS - 1))
                    state_next = (burst == BW'(MAX_BURSTS)) ? S_DONE : S_ON;
            end
            S_CLICK: begin
                if (bus.tick && cnt == CNT_W'(CLICK_MS - 1))
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Side-effect masks: DONE retires the owner's request, and an OFF expiry
    // into DONE (without ack) marks the alarm as missed.
    always_comb begin
        clr_mask = 4'b0000;
        miss_set = 3'b000;
        if (state == S_DONE)
            clr_mask = owner_vec;
        if (state == S_OFF && state_next == S_DONE && !bus.ack)
            miss_set = owner_vec[2:0];
    end

    // Datapath: tick counter, burst counter, owner, round-robin pointer,
    // pending and missed flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            burst   <= '0;
            owner   <= 2'd0;
            last_rr <= 2'd2;
            pending <= 4'b0000;
            missed  <= 3'b000;
        end else begin
            if (state == S_IDLE || state_next != state)
                cnt <= '0;
            else if (bus.tick)
                cnt <= cnt + CNT_W'(1);

            if (state == S_DONE)
                burst <= '0;
            else if (state == S_ON && state_next == S_OFF)
                burst <= burst + BW'(1);

            if (state == S_IDLE && state_next == S_ON)
                owner <= rr_pick;
            else if (state == S_IDLE && state_next == S_CLICK)
                owner <= 2'd3;

            if (state == S_DONE && owner != 2'd3)
                last_rr <= owner;

            pending <= (pending & ~clr_mask) | bus.req;
            missed  <= (missed | miss_set) & ~bus.req[2:0];
        end
    end

    // Output decode from the current state.
    always_comb begin
        bus.buzz_en = (state == S_ON) || (state == S_CLICK);
        bus.busy    = (state != S_IDLE);
        bus.grant   = (state != S_IDLE) ? owner_vec : 4'b0000;
        bus.pending = pending;
        bus.missed  = missed;
        bus.state   = state;
    end
endmodule

// File: tb/tb_alert_scheduler.sv
// Bench for alert_scheduler with short timing (ON=2, OFF=3, CLICK=1 ticks,
// 2 bursts, tick every 4 clocks). Each service is summarised as
// {grant, ON ticks, OFF ticks, missed at DONE} and matched against a queue.
module tb_alert_scheduler;
    localparam logic [2:0] ST_OFF  = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic clk;
    logic rst;
    alert_scheduler_if bif ();

    alert_scheduler #(
        .ON_MS(2), .OFF_MS(3), .CLICK_MS(1), .MAX_BURSTS(2), .CNT_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int tick_phase = 0;
    logic [14:0] exp_q[$];

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock of stimulus: inputs change 2 time units after the edge; tick
    // is generated here, req/ack default to idle for the cycle.
    task automatic step();
        @(posedge clk);
        #2;
        bif.tick = (tick_phase == 3);
        tick_phase = (tick_phase + 1) % 4;
        bif.req = 4'b0000;
        bif.ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Ack on the n-th tick heard while the target owner is buzzing.
    task automatic ack_at_tick(input logic [3:0] tgt, input int n);
        int seen = 0;
        int k = 0;
        while (k < 300) begin
            step();
            if (bif.grant == tgt && bif.tick && bif.buzz_en)
                seen++;
            if (seen == n) begin
                bif.ack = 1'b1;
                break;
            end
            k++;
        end
        check("ack_window", (k < 300), 1);
    endtask

    task automatic wait_grant(input logic [3:0] tgt);
        int k = 0;
        while (bif.grant != tgt && k < 300) begin
            step();
            k++;
        end
        check("wait_grant", (k < 300), 1);
    endtask

    task automatic wait_all();
        int k = 0;
        while ((exp_q.size() != 0 || bif.busy) && k < 600) begin
            step();
            k++;
        end
        check("drain", (k < 600), 1);
    endtask

    // Monitor: tally ON/OFF ticks per service, compare at DONE.
    int on_ticks = 0;
    int off_ticks = 0;
    always @(negedge clk) begin
        if (rst || !bif.busy) begin
            on_ticks = 0;
            off_ticks = 0;
        end else begin
            if (bif.tick && bif.buzz_en)
                on_ticks++;
            if (bif.tick && bif.state == ST_OFF)
                off_ticks++;
            if (bif.state == ST_DONE) begin
                if (exp_q.size() == 0)
                    check("unexpected_service", {17'd0, bif.grant, 4'(on_ticks), 4'(off_ticks), bif.missed}, 32'h7fff);
                else
                    check("service", {17'd0, bif.grant, 4'(on_ticks), 4'(off_ticks), bif.missed},
                          {17'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1;
        bif.tick = 1'b0;
        bif.req = 4'b0000;
        bif.ack = 1'b0;
        do_reset();

        // Reset state.
        check("rst_grant", bif.grant, 0);
        check("rst_buzz", bif.buzz_en, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_pending", bif.pending, 0);
        check("rst_missed", bif.missed, 0);

        // 1: unacknowledged alarm 0 runs both bursts and is marked missed.
        exp_q.push_back({4'b0001, 4'd4, 4'd6, 3'b001});
        step(); bif.req = 4'b0001;
        step();
        check("s1_pending", bif.pending, 4'b0001);
        check("s1_buzz_early", bif.buzz_en, 0);
        step();
        check("s1_grant", bif.grant, 4'b0001);
        check("s1_buzz", bif.buzz_en, 1);
        wait_all();
        check("s1_missed", bif.missed, 3'b001);
        check("s1_pending_clr", bif.pending, 0);
        check("s1_grant_clr", bif.grant, 0);

        // 2: ack on the second ON tick ends the alarm next cycle, not missed.
        exp_q.push_back({4'b0001, 4'd2, 4'd0, 3'b000});
        step(); bif.req = 4'b0001;
        ack_at_tick(4'b0001, 2);
        step();
        check("s2_state_done", bif.state, ST_DONE);
        check("s2_buzz_off", bif.buzz_en, 0);
        check("s2_missed", bif.missed, 0);
        wait_all();
        check("s2_pending_clr", bif.pending, 0);

        // 3: three alarms at once from reset serve 0,1,2; then 0,1.
        do_reset();
        exp_q.push_back({4'b0001, 4'd1, 4'd0, 3'b000});
        exp_q.push_back({4'b0010, 4'd1, 4'd0, 3'b000});
        exp_q.push_back({4'b0100, 4'd1, 4'd0, 3'b000});
        step(); bif.req = 4'b0111;
        ack_at_tick(4'b0001, 1);
        ack_at_tick(4'b0010, 1);
        ack_at_tick(4'b0100, 1);
        wait_all();
        exp_q.push_back({4'b0001, 4'd1, 4'd0, 3'b000});
        exp_q.push_back({4'b0010, 4'd1, 4'd0, 3'b000});
        step(); bif.req = 4'b0011;
        ack_at_tick(4'b0001, 1);
        ack_at_tick(4'b0010, 1);
        wait_all();

        // 4: click during alarm 1 waits until the alarm finishes.
        exp_q.push_back({4'b0010, 4'd4, 4'd6, 3'b010});
        exp_q.push_back({4'b1000, 4'd1, 4'd0, 3'b010});
        step(); bif.req = 4'b0010;
        wait_grant(4'b0010);
        step(); bif.req = 4'b1000;
        step();
        check("s4_pending", bif.pending, 4'b1010);
        check("s4_grant_hold", bif.grant, 4'b0010);
        wait_all();

        // 5: simultaneous alarm 0 and click: alarm first.
        exp_q.push_back({4'b0001, 4'd1, 4'd0, 3'b010});
        exp_q.push_back({4'b1000, 4'd1, 4'd0, 3'b010});
        step(); bif.req = 4'b1001;
        ack_at_tick(4'b0001, 1);
        wait_all();

        // 6: reset in OFF of alarm 2 aborts; alarm 1 then serves normally.
        step(); bif.req = 4'b0100;
        begin
            int k = 0;
            while (!(bif.grant == 4'b0100 && bif.state == ST_OFF) && k < 300) begin
                step();
                k++;
            end
            check("s6_reach_off", (k < 300), 1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s6_grant", bif.grant, 0);
        check("s6_buzz", bif.buzz_en, 0);
        check("s6_busy", bif.busy, 0);
        check("s6_pending", bif.pending, 0);
        check("s6_missed", bif.missed, 0);
        exp_q.push_back({4'b0010, 4'd1, 4'd0, 3'b000});
        step(); bif.req = 4'b0010;
        ack_at_tick(4'b0010, 1);
        wait_all();
        check("final_pending", bif.pending, 0);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/alert_scheduler.md
Name: alert_scheduler

Overview:
- Time-shares the single buzzer channel between three dose-reminder requesters (compartments 0-2) and one key-click requester (3).
- Sits between the main state machine / keypad path and the buzzer driver; buzz_en gates the buzzer tone.
- Dose alarms are round-robin arbitrated and sounded as ON/OFF bursts until the user acknowledges or the burst limit expires.
- Key clicks are low priority and sound as one short beep.

Parameters:
ON_MS, 200, burst ON length in tick periods
OFF_MS, 300, burst OFF length in tick periods
CLICK_MS, 20, key-click length in tick periods
MAX_BURSTS, 10, bursts before an unacknowledged alarm is abandoned
CNT_W, 10, width of tick counter (must hold max(ON_MS, OFF_MS, CLICK_MS))

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  single-cycle 1 ms enable (from 1 kHz divider, synchronised to clk)
req  in  4  request pulses: [2:0] dose due, [3] key click
ack  in  1  debounced single-cycle user acknowledge
buzz_en  out  1  buzzer enable
grant  out  4  one-hot owner of the buzzer, 0 when idle
busy  out  1  high in any state other than IDLE
pending  out  4  latched outstanding requests
missed  out  3  sticky per-compartment "alarm expired without ack"

Behaviour:
- Clocking and reset
  - All state changes on rising clk. Only the tick counter advances on tick.
  - rst (synchronous): state=IDLE; buzz_en=0, grant=0, busy=0, pending=0, missed=0; tick counter=0, burst counter=0.
  - rst sets last_rr=2, so the first round-robin pick is 0.
  - rst mid-alarm aborts the alarm at the next edge.
- Request latching
  - pending[i] is set the cycle after req[i]=1.
  - Set wins over a same-cycle clear.
  - req[i] for i<3 also clears missed[i].
  - A repeated req while pending or granted has no further effect.
- FSM states: IDLE, ON, OFF, CLICK, DONE.
- IDLE
  - If pending[2:0]!=0: grant the first pending index found searching from last_rr+1 mod 3 upward, then go to ON.
  - Else if pending[3]: grant 3, go to CLICK.
  - grant and buzz_en assert in the cycle the new state is entered.
  - Latency from req to buzz_en when idle: 2 cycles.
- Counter rule: the tick counter is zeroed on every state entry.
- ON
  - buzz_en=1.
  - On a tick with counter==ON_MS-1: go to OFF and increment the burst counter.
- OFF
  - buzz_en=0.
  - On a tick with counter==OFF_MS-1: go to DONE if burst counter==MAX_BURSTS, else go to ON.
  - On the DONE path, set missed[id].
- ack in ON or OFF
  - Go to DONE at the next edge, so buzz_en=0 the next cycle.
  - ack takes priority over a same-cycle counter expiry.
  - missed is not set on ack.
- CLICK
  - buzz_en=1.
  - On a tick with counter==CLICK_MS-1: go to DONE.
  - ack is ignored.
- DONE (1 cycle)
  - buzz_en=0; clear pending[id]; clear burst counter.
  - For id<3, set last_rr=id.
  - grant=0 from the next cycle; return to IDLE.
  - grant stays high during DONE.
- No preemption. Requests arriving during an alarm remain pending.
- ack in IDLE, CLICK or DONE is discarded.

Test Plan:
Bench parameters for all scenarios: ON_MS=2, OFF_MS=3, CLICK_MS=1, MAX_BURSTS=2; tick every 4 clk.
1. rst then req=0001 pulse at cycle 10:
   - pending=0001 at cycle 11; grant=0001, buzz_en=1 at cycle 12.
   - buzz_en pattern ON 2 ticks, OFF 3, ON 2, OFF 3.
   - Then DONE: missed=001, pending=0, grant=0.
2. Alarm 0 active, ack pulse in second ON tick:
   - buzz_en=0 and state DONE next cycle; missed stays 000; pending[0] cleared.
3. req=0111 in one cycle from IDLE:
   - Service order 0,1,2, each started after ack.
   - Then req=0011 with last_rr=2: order is 0 then 1.
4. req[3] during alarm 1:
   - pending=1010; click not sounded until alarm 1 DONE.
   - Then grant=1000 for exactly 1 tick of buzz_en=1.
5. req=1001 simultaneously from IDLE:
   - grant=0001 first; click follows after alarm DONE.
6. rst asserted in OFF of alarm 2:
   - Next cycle all outputs 0, pending=0.
   - Subsequent req[1] is granted normally with round-robin start at 0.
